// File: rtl/tconv_pkg.sv
// tconv_pkg: shared types for the transpose-conv layer scheduler.
// State encoding, default transpose opcode and status pulse bundle.
package tconv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_WAIT_BRAM   = 3'd2,
        ST_START_TRANS = 3'd3,
        ST_WAIT_TRANS  = 3'd4,
        ST_BATCH_END   = 3'd5,
        ST_DONE        = 3'd6
    } state_t;

    localparam logic [7:0] TRANS_OPCODE = 8'h03;

    typedef struct packed {
        logic batch_complete;
        logic done;
        logic aborted;
        logic cfg_error;
    } status_t;

endpackage

// File: rtl/tconv_pass_counter.sv
// tconv_pass_counter: nested row/tile/batch pass counter.
// Row runs fastest; a full tile sweep waits for an explicit batch step.
module tconv_pass_counter #(
    parameter int ROW_W   = 8,
    parameter int TILE_W  = 2,
    parameter int BATCH_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               inc_i,
    input  logic               inc_batch_i,
    input  logic [ROW_W:0]     rows_i,
    input  logic [TILE_W:0]    tiles_i,
    input  logic [BATCH_W:0]   batches_i,
    output logic [ROW_W-1:0]   row_o,
    output logic [TILE_W-1:0]  tile_o,
    output logic [BATCH_W-1:0] batch_o,
    output logic               last_row_o,
    output logic               last_tile_o,
    output logic               last_batch_o
);

    localparam logic [ROW_W:0]     ROW_ONE    = 1;
    localparam logic [TILE_W:0]    TILE_ONE   = 1;
    localparam logic [BATCH_W:0]   BATCH_ONE  = 1;
    localparam logic [ROW_W-1:0]   ROW_STEP   = 1;
    localparam logic [TILE_W-1:0]  TILE_STEP  = 1;
    localparam logic [BATCH_W-1:0] BATCH_STEP = 1;

    logic [ROW_W-1:0]   row_q,   row_d;
    logic [TILE_W-1:0]  tile_q,  tile_d;
    logic [BATCH_W-1:0] batch_q, batch_d;

    assign last_row_o   = ({1'b0, row_q} + ROW_ONE) == rows_i;
    assign last_tile_o  = ({1'b0, tile_q} + TILE_ONE) == tiles_i;
    assign last_batch_o = ({1'b0, batch_q} + BATCH_ONE) == batches_i;

    assign row_o   = row_q;
    assign tile_o  = tile_q;
    assign batch_o = batch_q;

    // Next pass position: row wraps into tile; batch step resets tile.
    always_comb begin
        row_d   = row_q;
        tile_d  = tile_q;
        batch_d = batch_q;
        if (clr_i) begin
            row_d   = '0;
            tile_d  = '0;
            batch_d = '0;
        end else if (inc_i) begin
            if (!last_row_o) begin
                row_d = row_q + ROW_STEP;
            end else begin
                row_d = '0;
                if (!last_tile_o) begin
                    tile_d = tile_q + TILE_STEP;
                end
            end
        end else if (inc_batch_i && !last_batch_o) begin
            tile_d  = '0;
            batch_d = batch_q + BATCH_STEP;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= '0;
            tile_q  <= '0;
            batch_q <= '0;
        end else begin
            row_q   <= row_d;
            tile_q  <= tile_d;
            batch_q <= batch_d;
        end
    end

endmodule

// File: rtl/tconv_layer_scheduler.sv
// tconv_layer_scheduler: run-time configurable transpose-conv layer sequencer.
// Walks row x tile x batch, issuing load pulses and transpose passes.
module tconv_layer_scheduler #(
    parameter int         ADDR_WIDTH   = 10,
    parameter int         ROW_W        = 8,
    parameter int         TILE_W       = 2,
    parameter int         BATCH_W      = 3,
    parameter int         IFMAP_SEL_W  = 4,
    parameter int         BRAM_WAIT    = 2,
    parameter logic [7:0] TRANS_OPCODE = tconv_pkg::TRANS_OPCODE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [1:0]                cfg_layer_id,
    input  logic [ROW_W:0]            cfg_rows,
    input  logic [TILE_W:0]           cfg_tiles,
    input  logic [BATCH_W:0]          cfg_batches,
    input  logic [ADDR_WIDTH:0]       cfg_if_seg_len,
    input  logic [ADDR_WIDTH:0]       cfg_w_seg_len,
    input  logic [8:0]                cfg_num_iter,
    input  logic                      trans_done,
    output logic                      start_mapper,
    output logic                      start_weight,
    output logic                      start_ifmap,
    output logic                      start_transpose,
    output logic [ADDR_WIDTH-1:0]     if_addr_start,
    output logic [ADDR_WIDTH-1:0]     if_addr_end,
    output logic [ADDR_WIDTH-1:0]     addr_start,
    output logic [ADDR_WIDTH-1:0]     addr_end,
    output logic [IFMAP_SEL_W-1:0]    ifmap_sel_in,
    output logic [7:0]                instruction_code,
    output logic [8:0]                num_iterations,
    output logic [ROW_W-1:0]          row_id,
    output logic [TILE_W+BATCH_W-1:0] tile_id,
    output logic [1:0]                layer_id,
    output logic                      busy,
    output logic                      batch_complete,
    output logic                      done,
    output logic                      aborted,
    output logic                      cfg_error
);

    import tconv_pkg::*;

    localparam int SEG_W  = ROW_W - IFMAP_SEL_W;
    localparam int TID_W  = TILE_W + BATCH_W;
    localparam int WAIT_W = (BRAM_WAIT > 1) ? $clog2(BRAM_WAIT) : 1;
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(BRAM_WAIT - 1);
    localparam logic [WAIT_W-1:0]     WAIT_STEP = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

    state_t state_q, state_d;
    status_t sts;

    logic [WAIT_W-1:0]     wait_q;
    logic [ROW_W:0]        rows_q;
    logic [TILE_W:0]       tiles_q;
    logic [BATCH_W:0]      batches_q;
    logic [ADDR_WIDTH:0]   if_len_q;
    logic [ADDR_WIDTH:0]   w_len_q;
    logic [8:0]            iter_q;
    logic [1:0]            lid_q;
    logic                  cfg_err_q;
    logic                  abort_q;

    logic [ROW_W-1:0]       row_h_q;
    logic [TID_W-1:0]       tid_h_q;
    logic [IFMAP_SEL_W-1:0] sel_h_q;
    logic [ADDR_WIDTH-1:0]  ifs_h_q, ife_h_q, ws_h_q, we_h_q;

    logic [ROW_W-1:0]   row_c;
    logic [TILE_W-1:0]  tile_c;
    logic [BATCH_W-1:0] batch_c;
    logic last_row, last_tile, last_batch;

    logic cfg_ok, accept, kill, wait_done;
    logic cnt_clr, cnt_inc, cnt_inc_batch, issuing;

    logic [SEG_W-1:0]      seg_c;
    logic [ADDR_WIDTH-1:0] if_len, w_len;
    logic [ADDR_WIDTH-1:0] ifs_c, ife_c, ws_c, we_c;

    assign cfg_ok = (cfg_rows != '0) && (cfg_tiles != '0)
                 && (cfg_batches != '0) && (cfg_if_seg_len != '0)
                 && (cfg_w_seg_len != '0);

    assign accept    = (state_q == ST_IDLE) && start && cfg_ok;
    assign kill      = (state_q != ST_IDLE) && abort;
    assign wait_done = (wait_q == WAIT_LAST);
    assign issuing   = (state_q == ST_ISSUE);

    assign cnt_clr       = accept || kill;
    assign cnt_inc       = (state_q == ST_WAIT_TRANS) && trans_done && !abort;
    assign cnt_inc_batch = (state_q == ST_BATCH_END) && !abort;

    tconv_pass_counter #(
        .ROW_W   (ROW_W),
        .TILE_W  (TILE_W),
        .BATCH_W (BATCH_W)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (cnt_clr),
        .inc_i        (cnt_inc),
        .inc_batch_i  (cnt_inc_batch),
        .rows_i       (rows_q),
        .tiles_i      (tiles_q),
        .batches_i    (batches_q),
        .row_o        (row_c),
        .tile_o       (tile_c),
        .batch_o      (batch_c),
        .last_row_o   (last_row),
        .last_tile_o  (last_tile),
        .last_batch_o (last_batch)
    );

    // Live BRAM ranges for the current pass; wraps modulo address space.
    assign seg_c  = row_c[ROW_W-1:IFMAP_SEL_W];
    assign if_len = if_len_q[ADDR_WIDTH-1:0];
    assign w_len  = w_len_q[ADDR_WIDTH-1:0];
    assign ifs_c  = ADDR_WIDTH'(seg_c) * if_len;
    assign ife_c  = ifs_c + if_len - ADDR_ONE;
    assign ws_c   = ADDR_WIDTH'(tile_c) * w_len;
    assign we_c   = ws_c + w_len - ADDR_ONE;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: pass walk, with abort overriding everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:        if (accept) state_d = ST_ISSUE;
            ST_ISSUE:       state_d = ST_WAIT_BRAM;
            ST_WAIT_BRAM:   if (wait_done) state_d = ST_START_TRANS;
            ST_START_TRANS: state_d = ST_WAIT_TRANS;
            ST_WAIT_TRANS: begin
                if (trans_done) begin
                    state_d = (last_row && last_tile) ? ST_BATCH_END : ST_ISSUE;
                end
            end
            ST_BATCH_END:   state_d = last_batch ? ST_DONE : ST_ISSUE;
            ST_DONE:        state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        start_mapper     = 1'b0;
        start_weight     = 1'b0;
        start_ifmap      = 1'b0;
        start_transpose  = 1'b0;
        instruction_code = '0;
        busy             = 1'b1;
        sts              = '0;
        unique case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_ISSUE: begin
                start_mapper = 1'b1;
                start_weight = 1'b1;
                start_ifmap  = 1'b1;
            end
            ST_START_TRANS: begin
                start_transpose  = 1'b1;
                instruction_code = TRANS_OPCODE;
            end
            ST_BATCH_END: sts.batch_complete = 1'b1;
            ST_DONE:      sts.done = 1'b1;
            default: ;
        endcase
        sts.cfg_error = cfg_err_q;
        sts.aborted   = abort_q;
    end

    assign batch_complete = sts.batch_complete;
    assign done           = sts.done;
    assign aborted        = sts.aborted;
    assign cfg_error      = sts.cfg_error;

    // Live values during ISSUE, then held until the next ISSUE.
    assign row_id        = issuing ? row_c : row_h_q;
    assign tile_id       = issuing ? {batch_c, tile_c} : tid_h_q;
    assign ifmap_sel_in  = issuing ? row_c[IFMAP_SEL_W-1:0] : sel_h_q;
    assign if_addr_start = issuing ? ifs_c : ifs_h_q;
    assign if_addr_end   = issuing ? ife_c : ife_h_q;
    assign addr_start    = issuing ? ws_c : ws_h_q;
    assign addr_end      = issuing ? we_c : we_h_q;
    assign num_iterations = iter_q;
    assign layer_id       = lid_q;

    // BRAM settle timer, only runs inside WAIT_BRAM.
    always_ff @(posedge clk) begin
        if (rst || (state_q != ST_WAIT_BRAM)) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + WAIT_STEP;
        end
    end

    // Config latch on any start seen in IDLE; status pulse flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q    <= '0;
            tiles_q   <= '0;
            batches_q <= '0;
            if_len_q  <= '0;
            w_len_q   <= '0;
            iter_q    <= '0;
            lid_q     <= '0;
            cfg_err_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                rows_q    <= cfg_rows;
                tiles_q   <= cfg_tiles;
                batches_q <= cfg_batches;
                if_len_q  <= cfg_if_seg_len;
                w_len_q   <= cfg_w_seg_len;
                iter_q    <= cfg_num_iter;
                lid_q     <= cfg_layer_id;
            end
            cfg_err_q <= (state_q == ST_IDLE) && start && !cfg_ok;
            abort_q   <= kill;
        end
    end

    // Capture the issued pass descriptor.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_h_q <= '0;
            tid_h_q <= '0;
            sel_h_q <= '0;
            ifs_h_q <= '0;
            ife_h_q <= '0;
            ws_h_q  <= '0;
            we_h_q  <= '0;
        end else if (issuing) begin
            row_h_q <= row_c;
            tid_h_q <= {batch_c, tile_c};
            sel_h_q <= row_c[IFMAP_SEL_W-1:0];
            ifs_h_q <= ifs_c;
            ife_h_q <= ife_c;
            ws_h_q  <= ws_c;
            we_h_q  <= we_c;
        end
    end

endmodule

// File: tb/tb_tconv_layer_scheduler.sv
// tb_tconv_layer_scheduler: scoreboard bench for the layer scheduler.
// Expected pass descriptors are queued at start and popped on each ISSUE.
module tb_tconv_layer_scheduler;

    localparam int AW        = 10;
    localparam int RW        = 8;
    localparam int TW        = 2;
    localparam int BW        = 3;
    localparam int SW        = 4;
    localparam int BRAM_WAIT = 2;

    typedef struct {
        int row;
        int tid;
        int sel;
        int ifs;
        int ife;
        int ws;
        int we;
    } exp_t;

    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic [1:0]     cfg_layer_id;
    logic [RW:0]    cfg_rows;
    logic [TW:0]    cfg_tiles;
    logic [BW:0]    cfg_batches;
    logic [AW:0]    cfg_if_seg_len;
    logic [AW:0]    cfg_w_seg_len;
    logic [8:0]     cfg_num_iter;
    logic           trans_done;
    logic start_mapper, start_weight, start_ifmap, start_transpose;
    logic [AW-1:0]  if_addr_start, if_addr_end, addr_start, addr_end;
    logic [SW-1:0]  ifmap_sel_in;
    logic [7:0]     instruction_code;
    logic [8:0]     num_iterations;
    logic [RW-1:0]  row_id;
    logic [TW+BW-1:0] tile_id;
    logic [1:0]     layer_id;
    logic busy, batch_complete, done, aborted, cfg_error;

    int n_chk  = 0;
    int n_pass = 0;
    int bc_cnt = 0;
    int done_cnt = 0;
    int ab_cnt = 0;
    int age = 0;
    bit prev_bc = 0;
    exp_t sb[$];
    exp_t e;

    tconv_layer_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_layer_id     (cfg_layer_id),
        .cfg_rows         (cfg_rows),
        .cfg_tiles        (cfg_tiles),
        .cfg_batches      (cfg_batches),
        .cfg_if_seg_len   (cfg_if_seg_len),
        .cfg_w_seg_len    (cfg_w_seg_len),
        .cfg_num_iter     (cfg_num_iter),
        .trans_done       (trans_done),
        .start_mapper     (start_mapper),
        .start_weight     (start_weight),
        .start_ifmap      (start_ifmap),
        .start_transpose  (start_transpose),
        .if_addr_start    (if_addr_start),
        .if_addr_end      (if_addr_end),
        .addr_start       (addr_start),
        .addr_end         (addr_end),
        .ifmap_sel_in     (ifmap_sel_in),
        .instruction_code (instruction_code),
        .num_iterations   (num_iterations),
        .row_id           (row_id),
        .tile_id          (tile_id),
        .layer_id         (layer_id),
        .busy             (busy),
        .batch_complete   (batch_complete),
        .done             (done),
        .aborted          (aborted),
        .cfg_error        (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int r, input int t, input int b,
                                input int ifl, input int wl);
        exp_t x;
        int seg;
        seg   = r / (1 << SW);
        x.row = r;
        x.tid = b * (1 << TW) + t;
        x.sel = r % (1 << SW);
        x.ifs = (seg * ifl) % (1 << AW);
        x.ife = (x.ifs + ifl - 1) % (1 << AW);
        x.ws  = (t * wl) % (1 << AW);
        x.we  = (x.ws + wl - 1) % (1 << AW);
        return x;
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({start_mapper, start_weight, start_ifmap,
                     start_transpose, if_addr_start, if_addr_end,
                     addr_start, addr_end, ifmap_sel_in,
                     instruction_code, num_iterations, row_id, tile_id,
                     layer_id, busy, batch_complete, done, aborted,
                     cfg_error});
    endfunction

    function automatic bit sig(input int w);
        case (w)
            0:       return start_mapper;
            1:       return start_transpose;
            default: return done;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, output bit ok);
        int n;
        n = 0;
        while (!sig(which) && n < 300) begin
            tick();
            n++;
        end
        ok = sig(which);
        if (!ok) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic set_cfg(input int rows, input int tiles, input int batches,
                           input int ifl, input int wl);
        cfg_rows       = (RW+1)'(rows);
        cfg_tiles      = (TW+1)'(tiles);
        cfg_batches    = (BW+1)'(batches);
        cfg_if_seg_len = (AW+1)'(ifl);
        cfg_w_seg_len  = (AW+1)'(wl);
        cfg_layer_id   = 2'((rows + tiles) % 4);
        cfg_num_iter   = 9'((rows * 3 + tiles) % 512);
    endtask

    // Sample every cycle: pop descriptor on ISSUE, track status pulses.
    always @(negedge clk) begin
        if (start_mapper || start_weight || start_ifmap) begin
            chk("ld_pulses", {start_mapper, start_weight, start_ifmap}, 3'b111);
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("row_id", row_id, e.row);
                chk("tile_id", tile_id, e.tid);
                chk("sel", ifmap_sel_in, e.sel);
                chk("if_start", if_addr_start, e.ifs);
                chk("if_end", if_addr_end, e.ife);
                chk("w_start", addr_start, e.ws);
                chk("w_end", addr_end, e.we);
            end
            age = 0;
        end else begin
            age++;
        end
        if (start_transpose) begin
            chk("bram_lat", age, BRAM_WAIT + 1);
            chk("opcode", instruction_code, 8'h03);
        end
        if (batch_complete) bc_cnt++;
        if (done) begin
            done_cnt++;
            chk("done_after_bc", prev_bc, 1);
        end
        if (aborted) ab_cnt++;
        prev_bc = batch_complete;
    end

    task automatic run_layer(input int rows, input int tiles, input int batches,
                             input int ifl, input int wl,
                             input int ab_pass, input bit poke);
        int total, nexp, k, bc0, d0, a0;
        bit ok;
        total = rows * tiles * batches;
        nexp  = (ab_pass >= 0) ? ab_pass + 1 : total;
        k = 0;
        for (int b = 0; b < batches; b++)
            for (int t = 0; t < tiles; t++)
                for (int r = 0; r < rows; r++) begin
                    if (k < nexp) sb.push_back(mk(r, t, b, ifl, wl));
                    k++;
                end
        bc0 = bc_cnt;
        d0  = done_cnt;
        a0  = ab_cnt;
        set_cfg(rows, tiles, batches, ifl, wl);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_run", busy, 1);
        chk("layer_id", layer_id, (rows + tiles) % 4);
        chk("num_iter", num_iterations, (rows * 3 + tiles) % 512);
        for (int p = 0; p < nexp; p++) begin
            wait_sig("issue", 0, ok);
            if (!ok) return;
            tick();
            if (poke && p == 0) begin
                trans_done = 1'b1;
                start      = 1'b1;
                cfg_rows   = (RW+1)'(1);
                tick();
                trans_done = 1'b0;
                start      = 1'b0;
                set_cfg(rows, tiles, batches, ifl, wl);
            end
            wait_sig("strans", 1, ok);
            if (!ok) return;
            tick();
            repeat ($urandom_range(0, 3)) tick();
            trans_done = 1'b1;
            if (p == ab_pass) abort = 1'b1;
            tick();
            trans_done = 1'b0;
            if (p == ab_pass) begin
                abort = 1'b0;
                chk("aborted", aborted, 1);
                chk("busy_abort", busy, 0);
                repeat (6) tick();
                chk("abort_once", ab_cnt - a0, 1);
                chk("no_done_abort", done_cnt - d0, 0);
                chk("no_bc_abort", bc_cnt - bc0, 0);
                chk("sb_abort", sb.size(), 0);
                return;
            end
        end
        wait_sig("done", 2, ok);
        if (!ok) return;
        tick();
        chk("done_once", done_cnt - d0, 1);
        chk("bc_count", bc_cnt - bc0, batches);
        chk("busy_end", busy, 0);
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        bit ok;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        trans_done = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_outs", all_outs(), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        run_layer(32, 4, 1, 256, 256, -1, 1'b1);
        run_layer(128, 1, 1, 128, 64, -1, 1'b0);
        run_layer(2, 4, 2, 16, 100, -1, 1'b0);
        run_layer(8, 1, 1, 64, 32, 5, 1'b0);
        run_layer(3, 2, 1, 32, 48, -1, 1'b0);

        set_cfg(4, 0, 1, 16, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cfg_err", cfg_error, 1);
        chk("cfg_err_busy", busy, 0);
        tick();
        chk("cfg_err_pulse", cfg_error, 0);
        chk("cfg_err_idle", busy, 0);

        sb.push_back(mk(0, 0, 0, 16, 16));
        set_cfg(4, 1, 1, 16, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sig("rst_issue", 0, ok);
        if (ok) begin
            tick();
            chk("in_wait_bram", busy, 1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("rst_mid_outs", all_outs(), 0);
            repeat (4) tick();
            chk("rst_mid_idle", busy, 0);
            chk("sb_rst", sb.size(), 0);
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
